// File: rtl/race_timer_text_if.sv
// Control, pixel and result signals between the race-timer overlay and its
// surroundings (control logic and VGA pixel pipeline).
interface race_timer_text_if;
  logic        start;
  logic        pause;
  logic        lap;
  logic        refresh_tick;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        text_on;
  logic [2:0]  bit_addr;
  logic [10:0] rom_addr;
  logic        running;
  logic        best_valid;
  logic        overflow;

  modport master (
    output start, pause, lap, refresh_tick, pix_x, pix_y,
    input  text_on, bit_addr, rom_addr, running, best_valid, overflow
  );

  modport slave (
    input  start, pause, lap, refresh_tick, pix_x, pix_y,
    output text_on, bit_addr, rom_addr, running, best_valid, overflow
  );
endinterface

// File: rtl/race_timer_text.sv
// Race-timer text overlay: BCD race time with start/pause/lap control and
// best-lap tracking, rendered as two text rows ("Time:ddd.d" / "Best:ddd.d")
// into font-ROM addresses for the shared 8x16 character ROM (pixels doubled).
module race_timer_text #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int INT_DIGITS = 3,
  parameter int ROW        = 0,
  parameter int COL0       = 0
) (
  input logic              clk,
  input logic              reset,
  race_timer_text_if.slave bus
);

  localparam int ND = INT_DIGITS + 1;
  localparam int W  = 4 * ND;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [31:0] NCELLS = 32'(INT_DIGITS + 7);
  localparam logic [31:0] ROW_U  = 32'(ROW);
  localparam logic [31:0] COL0_U = 32'(COL0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [W-1:0]  cur;
  logic [W-1:0]  best;
  logic          best_valid_q;
  logic          ovf_q;
  logic [W-1:0]  snap_cur;
  logic [W-1:0]  snap_best;
  logic          snap_bv;

  logic [W-1:0]  cur_inc;
  logic          cur_max;
  logic          tick_due;

  assign tick_due = (presc == PW'(TICK_DIV - 1));

  // BCD ripple increment of the current time; carry out of the top digit means all-9s
  always_comb begin
    logic carry;
    cur_inc = cur;
    carry   = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (carry) begin
        if (cur[4*i +: 4] == 4'd9) begin
          cur_inc[4*i +: 4] = 4'd0;
        end else begin
          cur_inc[4*i +: 4] = cur[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    cur_max = carry;
  end

  // Timer state: start beats lap, lap beats the prescaler tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      cur          <= '0;
      best         <= '0;
      best_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (bus.start) begin
      cur   <= '0;
      presc <= '0;
      ovf_q <= 1'b0;
      state <= bus.pause ? PAUSED : RUN;
    end else begin
      if (state == RUN && bus.pause) begin
        state <= PAUSED;
      end else if (state == PAUSED && !bus.pause) begin
        state <= RUN;
      end

      if (bus.lap && state != IDLE) begin
        // BCD digits compare correctly as one unsigned vector
        if (!best_valid_q || cur < best) begin
          best         <= cur;
          best_valid_q <= 1'b1;
        end
        cur   <= '0;
        presc <= '0;
        ovf_q <= 1'b0;
      end else if (state == RUN) begin
        if (tick_due) begin
          presc <= '0;
          if (cur_max) begin
            ovf_q <= 1'b1;
          end else begin
            cur <= cur_inc;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // Per-frame display snapshot so a line never tears mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_cur  <= '0;
      snap_best <= '0;
      snap_bv   <= 1'b0;
    end else if (bus.refresh_tick) begin
      snap_cur  <= cur;
      snap_best <= best;
      snap_bv   <= best_valid_q;
    end
  end

  assign bus.running    = (state == RUN);
  assign bus.best_valid = best_valid_q;
  assign bus.overflow   = ovf_q;

  logic [31:0] col;
  logic [31:0] row;
  logic [31:0] c;
  logic [31:0] didx;
  logic        on_time;
  logic        on_best;
  logic        text_on_c;
  logic [W-1:0] sel;
  logic [3:0]  nib;
  logic [6:0]  char_addr;
  logic [6:0]  label_char;

  // Character cell lookup from the current pixel and the snapshots
  always_comb begin
    col       = 32'(bus.pix_x[9:4]);
    row       = 32'(bus.pix_y[9:5]);
    c         = col - COL0_U;
    on_time   = (row == ROW_U);
    on_best   = (row == ROW_U + 32'd1);
    text_on_c = (on_time || on_best) && (col >= COL0_U) && (c < NCELLS);
    sel       = on_best ? snap_best : snap_cur;
    // Last cell is tenths (nibble 0); integer cells map MSD-first onto the upper nibbles
    didx      = (c == NCELLS - 32'd1) ? 32'd0 : 32'(INT_DIGITS + 5) - c;
    nib       = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (didx == 32'(i)) nib = sel[4*i +: 4];
    end

    label_char = 7'h3A;
    if (on_best) begin
      case (c[2:0])
        3'd0:    label_char = 7'h42;
        3'd1:    label_char = 7'h65;
        3'd2:    label_char = 7'h73;
        3'd3:    label_char = 7'h74;
        default: label_char = 7'h3A;
      endcase
    end else begin
      case (c[2:0])
        3'd0:    label_char = 7'h54;
        3'd1:    label_char = 7'h69;
        3'd2:    label_char = 7'h6D;
        3'd3:    label_char = 7'h65;
        default: label_char = 7'h3A;
      endcase
    end

    char_addr = '0;
    if (text_on_c) begin
      if (c < 32'd5) begin
        char_addr = label_char;
      end else if (c == NCELLS - 32'd2) begin
        char_addr = 7'h2E;
      end else if (on_best && !snap_bv) begin
        char_addr = 7'h2D;
      end else begin
        char_addr = {3'b011, nib};
      end
    end
  end

  assign bus.text_on  = text_on_c;
  assign bus.bit_addr = bus.pix_x[3:1];
  assign bus.rom_addr = {char_addr, bus.pix_y[4:1]};

endmodule

// File: tb/tb_race_timer_text.sv
// Bench for race_timer_text: two instances (4-digit and 2-digit time) compared
// against an integer-tenths reference model and a decimal text renderer.
module tb_race_timer_text;
  localparam int TDA = 4, IDA = 3, ROWA = 3, COLA = 5, NA = IDA + 7;
  localparam int TDB = 2, IDB = 1, NB = IDB + 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  race_timer_text_if ia();
  race_timer_text_if ib();

  race_timer_text #(.TICK_DIV(TDA), .INT_DIGITS(IDA), .ROW(ROWA), .COL0(COLA)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave));
  race_timer_text #(.TICK_DIV(TDB), .INT_DIGITS(IDB), .ROW(0), .COL0(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave));

  typedef struct {
    int mode;   // 0 idle, 1 run, 2 paused
    int cur;    // tenths of a second
    int pre;
    int best;
    bit bv;
    bit ovf;
    int scur;
    int sbest;
    bit sbv;
  } mstate_t;

  mstate_t ma = '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
  mstate_t mb = '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
  int n_cmp = 0;
  int n_err = 0;

  function automatic mstate_t step(mstate_t s, bit rst, bit st, bit pa, bit lp, bit rf,
                                   int td, int maxv);
    mstate_t n = s;
    if (rst) return '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
    if (rf) begin n.scur = s.cur; n.sbest = s.best; n.sbv = s.bv; end
    if (st) begin
      n.cur = 0; n.pre = 0; n.ovf = 0; n.mode = pa ? 2 : 1;
    end else begin
      if (s.mode == 1 && pa) n.mode = 2;
      else if (s.mode == 2 && !pa) n.mode = 1;
      if (lp && s.mode != 0) begin
        if (!s.bv || s.cur < s.best) begin n.best = s.cur; n.bv = 1; end
        n.cur = 0; n.pre = 0; n.ovf = 0;
      end else if (s.mode == 1) begin
        if (s.pre == td - 1) begin
          n.pre = 0;
          if (s.cur == maxv) n.ovf = 1;
          else n.cur = s.cur + 1;
        end else begin
          n.pre = s.pre + 1;
        end
      end
    end
    return n;
  endfunction

  // Expected character for line ln (0 time, 1 best, else none) and cell c
  function automatic logic [6:0] exp_char(int ln, int c, int id, int sc, int sb, bit sbv);
    string lbl;
    int n = id + 7;
    int v;
    int p;
    if (ln < 0 || ln > 1 || c < 0 || c >= n) return 7'h00;
    if (ln == 0) lbl = "Time:"; else lbl = "Best:";
    if (c < 5) return 7'(lbl[c]);
    if (c == n - 2) return 7'h2E;
    if (ln == 1 && !sbv) return 7'h2D;
    v = (ln == 1) ? sb : sc;
    p = (c == n - 1) ? 0 : id + 5 - c;
    for (int k = 0; k < p; k++) v = v / 10;
    return {3'b011, 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, reset, ia.start, ia.pause, ia.lap, ia.refresh_tick, TDA, 9999);
    mb <= step(mb, reset, ib.start, ib.pause, ib.lap, ib.refresh_tick, TDB, 99);
  end

  task automatic set_a(int ln, int c);
    ia.pix_x = 10'((COLA + c) * 16 + 6);
    ia.pix_y = 10'((ROWA + ln) * 32 + 10);
  endtask

  task automatic pulse_refresh_a();
    ia.refresh_tick = 1'b1; @(negedge clk); ia.refresh_tick = 1'b0;
  endtask

  task automatic wait_cur_a(int target, int pre_req, string tag);
    for (int k = 0; k < 1000 && !(ma.cur == target && (pre_req < 0 || ma.pre == pre_req)); k++)
      @(negedge clk);
    if (!(ma.cur == target && (pre_req < 0 || ma.pre == pre_req))) begin
      n_err++;
      $display("FAIL %s timeout: time %0d never reached", tag, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    n_cmp++;
    if ({ia.running, ia.best_valid, ia.overflow} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b want 000", {ia.running, ia.best_valid, ia.overflow});
    end
    for (int ln = 0; ln < 3; ln++)
      for (int c = -1; c <= NA; c++) begin
        int ry, bx; logic [6:0] ec; logic eon;
        ry = $urandom_range(15); bx = $urandom_range(7);
        ia.pix_x = 10'((COLA + c) * 16 + bx * 2 + int'($urandom_range(1)));
        ia.pix_y = 10'((ROWA + ln) * 32 + ry * 2 + int'($urandom_range(1)));
        #1;
        ec = exp_char(ln, c, IDA, ma.scur, ma.sbest, ma.sbv);
        eon = (ln < 2) && (c >= 0) && (c < NA);
        n_cmp++;
        if ({ia.text_on, ia.bit_addr, ia.rom_addr} !== {eon, 3'(bx), ec, 4'(ry)}) begin
          n_err++;
          $display("FAIL reset_scan ln=%0d c=%0d got on=%b bit=%0d rom=%h want on=%b bit=%0d rom=%h",
                   ln, c, ia.text_on, ia.bit_addr, ia.rom_addr, eon, bx, {ec, 4'(ry)});
        end
        @(negedge clk);
      end
  endtask

  task automatic test_count();
    int cells[4];
    logic [6:0] wants[4];
    cells = '{5, NA - 1, NA - 2, NA - 3};
    wants = '{7'h30, 7'h30, 7'h2E, 7'h31};
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    n_cmp++;
    if (ia.running !== 1'b1) begin n_err++; $display("FAIL count_running got %b want 1", ia.running); end
    repeat (40) @(negedge clk);
    pulse_refresh_a();
    for (int k = 0; k < 4; k++) begin
      set_a(0, cells[k]); #1;
      n_cmp++;
      if (ia.rom_addr[10:4] !== wants[k]) begin
        n_err++; $display("FAIL count_cell c=%0d got %h want %h", cells[k], ia.rom_addr[10:4], wants[k]);
      end
    end
    for (int ln = 0; ln < 2; ln++)
      for (int c = 0; c <= NA; c++) begin
        logic [6:0] ec;
        set_a(ln, c); #1;
        ec = exp_char(ln, c, IDA, ma.scur, ma.sbest, ma.sbv);
        n_cmp++;
        if ({ia.text_on, ia.rom_addr[10:4]} !== {c < NA, ec}) begin
          n_err++;
          $display("FAIL count_scan ln=%0d c=%0d got on=%b ch=%h want on=%b ch=%h",
                   ln, c, ia.text_on, ia.rom_addr[10:4], c < NA, ec);
        end
      end
    @(negedge clk);
  endtask

  task automatic test_pause();
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    wait_cur_a(7, -1, "pause_wait");
    ia.pause = 1'b1;
    set_a(0, NA - 1);
    for (int k = 0; k < 20 + 6; k++) begin
      logic [6:0] ec;
      if (k == 20) ia.pause = 1'b0;
      ia.refresh_tick = 1'b1; @(negedge clk); ia.refresh_tick = 1'b0; #1;
      ec = exp_char(0, NA - 1, IDA, ma.scur, ma.sbest, ma.sbv);
      n_cmp++;
      if ({ia.running, ia.rom_addr[10:4]} !== {ma.mode == 1, ec}) begin
        n_err++;
        $display("FAIL pause_step k=%0d got run=%b ch=%h want run=%b ch=%h",
                 k, ia.running, ia.rom_addr[10:4], ma.mode == 1, ec);
      end
    end
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h38) begin
      n_err++; $display("FAIL pause_resume got %h want 38", ia.rom_addr[10:4]);
    end
    @(negedge clk);
  endtask

  task automatic test_lap();
    int tg[3];
    tg = '{53, 21, 40};
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cur_a(tg[i], -1, "lap_wait");
      ia.lap = 1'b1; @(negedge clk); ia.lap = 1'b0;
      pulse_refresh_a();
      set_a(0, NA - 1); #1;
      n_cmp++;
      if (ia.rom_addr[10:4] !== 7'h30) begin
        n_err++; $display("FAIL lap_clear i=%0d got %h want 30", i, ia.rom_addr[10:4]);
      end
    end
    n_cmp++;
    if (ia.best_valid !== 1'b1) begin n_err++; $display("FAIL lap_bv got %b want 1", ia.best_valid); end
    set_a(1, NA - 1); #1;
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h31) begin n_err++; $display("FAIL lap_best_tenths got %h want 31", ia.rom_addr[10:4]); end
    set_a(1, NA - 3); #1;
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h32) begin n_err++; $display("FAIL lap_best_units got %h want 32", ia.rom_addr[10:4]); end
    for (int c = 0; c < NA; c++) begin
      logic [6:0] ec;
      set_a(1, c); #1;
      ec = exp_char(1, c, IDA, ma.scur, ma.sbest, ma.sbv);
      n_cmp++;
      if (ia.rom_addr[10:4] !== ec) begin
        n_err++; $display("FAIL lap_scan c=%0d got %h want %h", c, ia.rom_addr[10:4], ec);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lap_tick();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    wait_cur_a(4, TDA - 1, "laptick_wait");
    ia.lap = 1'b1; @(negedge clk); ia.lap = 1'b0;
    pulse_refresh_a();
    set_a(1, NA - 1); #1;
    n_cmp++;
    if ({ia.best_valid, ia.rom_addr[10:4]} !== {1'b1, 7'h34}) begin
      n_err++; $display("FAIL laptick_best got bv=%b ch=%h want bv=1 ch=34", ia.best_valid, ia.rom_addr[10:4]);
    end
    set_a(0, NA - 1); #1;
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h30) begin n_err++; $display("FAIL laptick_cur got %h want 30", ia.rom_addr[10:4]); end
    wait_cur_a(2, -1, "startlap_wait");
    ia.start = 1'b1; ia.lap = 1'b1; @(negedge clk); ia.start = 1'b0; ia.lap = 1'b0;
    pulse_refresh_a();
    for (int ln = 0; ln < 2; ln++)
      for (int c = 0; c < NA; c++) begin
        logic [6:0] ec;
        set_a(ln, c); #1;
        ec = exp_char(ln, c, IDA, ma.scur, ma.sbest, ma.sbv);
        n_cmp++;
        if (ia.rom_addr[10:4] !== ec) begin
          n_err++; $display("FAIL startlap_scan ln=%0d c=%0d got %h want %h", ln, c, ia.rom_addr[10:4], ec);
        end
      end
    set_a(1, NA - 1); #1;
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h34) begin n_err++; $display("FAIL startlap_best got %h want 34", ia.rom_addr[10:4]); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    ib.start = 1'b1; @(negedge clk); ib.start = 1'b0;
    for (int k = 0; k < 400 && !mb.ovf; k++) @(negedge clk);
    if (!mb.ovf) begin n_err++; $display("FAIL ovf_wait timeout"); end
    n_cmp++;
    if (ib.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ib.overflow); end
    repeat (6) @(negedge clk);
    ib.refresh_tick = 1'b1; @(negedge clk); ib.refresh_tick = 1'b0;
    for (int c = 0; c <= NB; c++) begin
      logic [6:0] ec;
      ib.pix_x = 10'(c * 16 + 4); ib.pix_y = 10'd6; #1;
      ec = exp_char(0, c, IDB, mb.scur, mb.sbest, mb.sbv);
      n_cmp++;
      if ({ib.text_on, ib.rom_addr} !== {c < NB, ec, 4'd3}) begin
        n_err++; $display("FAIL ovf_scan c=%0d got on=%b rom=%h want on=%b rom=%h",
                          c, ib.text_on, ib.rom_addr, c < NB, {ec, 4'd3});
      end
    end
    ib.pix_x = 10'((NB - 1) * 16); #1;
    n_cmp++;
    if (ib.rom_addr[10:4] !== 7'h39) begin n_err++; $display("FAIL ovf_hold got %h want 39", ib.rom_addr[10:4]); end
    @(negedge clk);
    ib.start = 1'b1; @(negedge clk); ib.start = 1'b0;
    n_cmp++;
    if (ib.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ib.overflow); end
    ib.refresh_tick = 1'b1; @(negedge clk); ib.refresh_tick = 1'b0; #1;
    n_cmp++;
    if (ib.rom_addr[10:4] !== 7'h30) begin n_err++; $display("FAIL ovf_restart got %h want 30", ib.rom_addr[10:4]); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    repeat (30) @(negedge clk);
    ia.lap = 1'b1; @(negedge clk); ia.lap = 1'b0;
    repeat (10) @(negedge clk);
    pulse_refresh_a();
    reset = 1'b1; @(negedge clk);
    n_cmp++;
    if ({ia.running, ia.best_valid, ia.overflow} !== 3'b000) begin
      n_err++; $display("FAIL midrun_flags got %b want 000", {ia.running, ia.best_valid, ia.overflow});
    end
    reset = 1'b0;
    ia.lap = 1'b1; @(negedge clk); ia.lap = 1'b0;
    pulse_refresh_a();
    n_cmp++;
    if ({ia.running, ia.best_valid} !== 2'b00) begin
      n_err++; $display("FAIL idle_lap got %b want 00", {ia.running, ia.best_valid});
    end
    for (int ln = 0; ln < 2; ln++)
      for (int c = 0; c < NA; c++) begin
        logic [6:0] ec;
        set_a(ln, c); #1;
        ec = exp_char(ln, c, IDA, ma.scur, ma.sbest, ma.sbv);
        n_cmp++;
        if (ia.rom_addr[10:4] !== ec) begin
          n_err++; $display("FAIL midrun_scan ln=%0d c=%0d got %h want %h", ln, c, ia.rom_addr[10:4], ec);
        end
      end
    set_a(1, 5); #1;
    n_cmp++;
    if (ia.rom_addr[10:4] !== 7'h2D) begin n_err++; $display("FAIL idle_dash got %h want 2D", ia.rom_addr[10:4]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      int ln, c;
      logic [6:0] ec;
      ia.start        = ($urandom_range(39) == 0);
      ia.lap          = ($urandom_range(14) == 0);
      ia.refresh_tick = ($urandom_range(4) == 0);
      if ($urandom_range(29) == 0) ia.pause = ~ia.pause;
      ln = $urandom_range(1); c = $urandom_range(NA - 1);
      set_a(ln, c);
      @(negedge clk); #1;
      ec = exp_char(ln, c, IDA, ma.scur, ma.sbest, ma.sbv);
      n_cmp++;
      if ({ia.running, ia.best_valid, ia.overflow, ia.text_on, ia.rom_addr[10:4]} !==
          {ma.mode == 1, ma.bv, ma.ovf, 1'b1, ec}) begin
        n_err++;
        $display("FAIL random k=%0d got run/bv/ovf/on=%b%b%b%b ch=%h want %b%b%b1 ch=%h", k,
                 ia.running, ia.best_valid, ia.overflow, ia.text_on, ia.rom_addr[10:4],
                 ma.mode == 1, ma.bv, ma.ovf, ec);
      end
    end
    ia.start = 1'b0; ia.lap = 1'b0; ia.refresh_tick = 1'b0; ia.pause = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ia.start = 1'b0; ia.pause = 1'b0; ia.lap = 1'b0; ia.refresh_tick = 1'b0;
    ia.pix_x = '0; ia.pix_y = '0;
    ib.start = 1'b0; ib.pause = 1'b0; ib.lap = 1'b0; ib.refresh_tick = 1'b0;
    ib.pix_x = '0; ib.pix_y = '0;
    @(negedge clk);
    test_reset();
    test_count();
    test_pause();
    test_lap();
    test_lap_tick();
    test_overflow();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/race_timer_text.md
# race_timer_text

Parametrised race-timer text overlay for the VGA pipeline. Keeps a BCD race time driven by a clock prescaler, with start, pause and lap control, and tracks the best lap. It renders two text rows ("Time:ddd.d" and "Best:ddd.d") as font-ROM addresses for the shared 8x16 character ROM. Pixels are doubled, so each cell is 16x32. It sits beside the other text generators and feeds the pixel mux.

## Interface
- TICK_DIV, 10_000_000, clk cycles per 0.1 s time unit (>=2)
- INT_DIGITS, 3, integer-second digits (1..6); tenths digit always present
- ROW, 0, 32-px text row (pix_y[9:5]) of the "Time" line; "Best" line is ROW+1
- COL0, 0, first 16-px cell (pix_x[9:4]) of both lines
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: clear current time and run
- pause  in  1  level: freeze timer while high
- lap  in  1  one-cycle pulse: record lap and restart current time
- refresh_tick  in  1  one-cycle pulse per frame: latch display snapshot
- pix_x, pix_y  in  10 each  current pixel
- text_on  out  1  pixel lies inside either text line
- bit_addr  out  3  font column, pix_x[3:1]
- rom_addr  out  11  {char_addr[6:0], pix_y[4:1]}
- running  out  1  state is RUN
- best_valid  out  1  a best lap exists
- overflow  out  1  current time saturated

## Operation
- States: IDLE, RUN, PAUSED.
  - IDLE --start--> RUN.
  - RUN --pause=1--> PAUSED.
  - PAUSED --pause=0--> RUN.
  - start in RUN or PAUSED clears the current time and the prescaler, clears overflow, and enters RUN. If pause=1 on that cycle, it enters PAUSED instead.
- Current time `cur` is (INT_DIGITS+1) BCD digits, tenths digit least significant. No division or modulo is used; digits carry as a BCD ripple.
- Prescaler counts 0..TICK_DIV-1 only in RUN. At TICK_DIV-1 it wraps to 0 and `cur` increments by 1. In PAUSED the prescaler holds (it is not cleared).
- Saturation: an increment with `cur` at all-9s leaves `cur` unchanged and sets overflow. overflow stays set until start or reset.
- lap is accepted in RUN or PAUSED; it is ignored in IDLE.
  - If !best_valid, or `cur` < best, then best <= `cur` and best_valid <= 1.
  - BCD compare equals unsigned compare of the concatenated nibbles.
  - Then `cur` <= 0, prescaler <= 0, and overflow <= 0.
- Priority on the same cycle: reset > start > lap > tick increment.
  - For lap coinciding with a tick, the pre-increment value is recorded.
- Display: on refresh_tick, snap_cur <= `cur`, snap_best <= best and snap_bv <= best_valid. The pixel path uses only the snapshots.
- Rendering: c = pix_x[9:4] - COL0, for lines at pix_y[9:5] = ROW or ROW+1, with N = INT_DIGITS+7 cells per line.
  - text_on = 1 when c is in 0..N-1.
  - Cells 0..4 show "Time:" (54 69 6D 65 3A) or "Best:" (42 65 73 74 3A).
  - Cells 5..4+INT_DIGITS show integer digits, most significant first.
  - The next cell shows "." (2E); the last cell shows the tenths digit.
  - A digit glyph is {3'b011, d}.
  - On the Best line with snap_bv=0, every digit cell shows "-" (2D).
  - Outside the lines, char_addr=00.

## Timing
- Reset values: state IDLE, `cur`/best/snapshots/prescaler 0, running 0, best_valid 0, overflow 0, snap_bv 0.
- Control inputs are sampled at the clk edge. running reflects the state one cycle after start.
- The first increment occurs TICK_DIV cycles after the start edge, then every TICK_DIV cycles in RUN.
- best_valid and best update on the edge that samples lap; the display shows them after the next refresh_tick.
- text_on, bit_addr and rom_addr are combinational from pix_x/pix_y and the snapshots, with zero latency.
- Reset mid-run returns to IDLE at once and discards best.

## Test plan
- TICK_DIV=4, INT_DIGITS=3: start, run 40 cycles, refresh_tick -> snap_cur=001.0. Cell 5 at ROW gives rom_addr[10:4]=30; the tenths cell gives 30; the cell before it gives 2E.
- Run to 0.7, then pause for 20 cycles and resume: the next increment comes exactly at the remaining prescaler count and `cur` reads 0.8. No increments occur while paused.
- Lap at 5.3, then lap at 2.1, then lap at 4.0 -> best = 2.1, best_valid=1. Each lap leaves `cur`=0.0. Lap in IDLE leaves `cur`, best and best_valid unchanged.
- INT_DIGITS=1, TICK_DIV=2: run past 9.9 -> `cur` holds 9.9 and overflow=1. start -> `cur`=0.0 and overflow=0.
- Lap on the same cycle as a tick at 0.4 -> recorded value is 0.4 and `cur`=0.0. start together with lap -> best is unchanged.
- Before any lap, the Best line digit cells give char 2D. A pixel at c=N gives text_on=0. Reset mid-RUN -> all outputs return to their reset values on the next edge.
